if_fetch: RTL and testbench

- Instruction-fetch stage; directly upstream of the IF/ID pipeline register.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Buffers one returned word with its PC+4 and presents it on IF_pc4/IF_instr/IF_valid for IF/ID to latch.
- Honours stall from the hazard unit and redirect from branch/jump resolution.

---
 rtl/if_pkg.sv | 13 +
 rtl/if_fetch_if.sv | 20 ++
 rtl/if_perf_counters.sv | 26 ++
 rtl/if_fetch.sv | 131 +++++++++++++
 tb/tb_if_fetch.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int          PC_INC           = 4;

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory request/response bus between fetch (master) and imem (slave).
interface if_fetch_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/if_perf_counters.sv
// Fetch-stage event counters (built only with IF_PERF_CNT_EN); all wrap at 2^32.
module if_perf_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        consume,
  input  logic        stall_hit,
  input  logic        kill,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] kill_cnt
);

  // Count consumptions, stalled-full cycles and dropped wrong-path responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
      kill_cnt  <= '0;
    end else begin
      if (consume)   fetch_cnt <= fetch_cnt + 32'd1;
      if (stall_hit) stall_cnt <= stall_cnt + 32'd1;
      if (kill)      kill_cnt  <= kill_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight and
// buffers one returned word for IF/ID. Optional IF_PERF_CNT_EN adds counters.
module if_fetch
  import if_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  if_fetch_if.master        imem,
  output logic [ADDR_W-1:0] IF_pc4,
  output logic [31:0]       IF_instr,
  output logic              IF_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_kill_cnt
`endif
);

  localparam logic [ADDR_W-1:0] INC        = ADDR_W'(PC_INC);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] req_pc, req_pc_nxt;
  logic [ADDR_W-1:0] pc4_q, pc4_nxt;
  logic [31:0]       instr_q, instr_nxt;
  logic              o_valid, valid_nxt;
  logic              accept, consume;
  logic [ADDR_W-1:0] req_pc_inc;

  // Issue only when the buffer is empty or is being drained this cycle, so a
  // response can never land on an unconsumed word. Held low during reset.
  assign imem.imem_req  = rst_n && (state == REQ) && (!o_valid || !stall);
  assign imem.imem_addr = pc;

  assign accept     = imem.imem_req && imem.imem_ready;
  assign consume    = o_valid && !stall;
  assign req_pc_inc = req_pc + INC;

  assign IF_pc4   = pc4_q;
  assign IF_instr = instr_q;
  assign IF_valid = o_valid;

  // State register and fetch datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= REQ;
      pc      <= RESET_PC & ALIGN_MASK;
      req_pc  <= '0;
      pc4_q   <= '0;
      instr_q <= '0;
      o_valid <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      req_pc  <= req_pc_nxt;
      pc4_q   <= pc4_nxt;
      instr_q <= instr_nxt;
      o_valid <= valid_nxt;
    end
  end

  // Next-state: normal fetch flow first, then redirect overrides everything.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    req_pc_nxt = req_pc;
    pc4_nxt    = pc4_q;
    instr_nxt  = instr_q;
    valid_nxt  = o_valid;

    if (consume) valid_nxt = 1'b0;

    case (state)
      REQ: begin
        if (accept) begin
          req_pc_nxt = pc;
          state_nxt  = WAIT;
        end
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          instr_nxt = imem.imem_rdata;
          pc4_nxt   = req_pc_inc;
          valid_nxt = 1'b1;
          pc_nxt    = req_pc_inc;
          state_nxt = REQ;
        end
      end
      DRAIN: begin
        // Wrong-path response: drop it, pc already holds the new target.
        if (imem.imem_rvalid) state_nxt = REQ;
      end
      default: state_nxt = REQ;
    endcase

    if (redirect_valid) begin
      pc_nxt    = redirect_pc & ALIGN_MASK;
      valid_nxt = 1'b0;
      pc4_nxt   = pc4_q;
      instr_nxt = instr_q;
      // DRAIN only if a response is still owed after this edge.
      case (state)
        REQ:         state_nxt = accept ? DRAIN : REQ;
        WAIT, DRAIN: state_nxt = imem.imem_rvalid ? REQ : DRAIN;
        default:     state_nxt = REQ;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  if_perf_counters u_perf (
    .clk       (clk),
    .rst_n     (rst_n),
    .consume   (consume),
    .stall_hit (o_valid && stall),
    .kill      ((state == DRAIN) && imem.imem_rvalid),
    .fetch_cnt (perf_fetch_cnt),
    .stall_cnt (perf_stall_cnt),
    .kill_cnt  (perf_kill_cnt)
  );
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a latency-programmable imem model.
module tb_if_fetch;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] IF_pc4;
  logic [31:0] IF_instr;
  logic        IF_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_kill_cnt;
`endif

  int ntests = 0;
  int nfail  = 0;

  if_fetch_if #(.ADDR_W(32)) imem ();

  if_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_3000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem),
    .IF_pc4         (IF_pc4),
    .IF_instr       (IF_instr),
    .IF_valid       (IF_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_kill_cnt  (perf_kill_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: one fixed word at 0x3000, everything else addr ^ 0xDEAD0000.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0000_3000) ? 32'h2408_0001 : (a ^ 32'hDEAD_0000);
  endfunction

  int          lat;
  logic        mbusy;
  int          mdly;
  logic [31:0] maddr;

  // Memory model: capture handshakes at the clock edge (pre-update values).
  always @(posedge clk) begin
    if (!rst_n) begin
      mbusy = 1'b0;
    end else begin
      if (imem.imem_rvalid) mbusy = 1'b0;
      if (imem.imem_req && imem.imem_ready) begin
        mbusy = 1'b1;
        mdly  = lat;
        maddr = imem.imem_addr;
      end
    end
  end

  // Memory model: drive the response mid-cycle, lat cycles after accept.
  always @(negedge clk) begin
    if (!rst_n || !mbusy) begin
      imem.imem_rvalid = 1'b0;
    end else if (mdly == 1) begin
      imem.imem_rvalid = 1'b1;
      imem.imem_rdata  = mem_word(maddr);
    end else begin
      imem.imem_rvalid = 1'b0;
      mdly = mdly - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    lat = 1; mbusy = 1'b0; mdly = 0; maddr = '0;
    imem.imem_ready = 1'b1; imem.imem_rvalid = 1'b0; imem.imem_rdata = '0;

    // Reset values
    step();
    chk("rst_req",   {31'd0, imem.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, IF_valid},      32'd0);
    chk("rst_instr", IF_instr,               32'd0);
    chk("rst_pc4",   IF_pc4,                 32'd0);
    chk("rst_addr",  imem.imem_addr,         32'h0000_3000);
`ifdef IF_PERF_CNT_EN
    chk("rst_perf",  perf_fetch_cnt | perf_stall_cnt | perf_kill_cnt, 32'd0);
`endif

    // First fetch with 1-cycle memory
    rst_n = 1'b1; #1;
    chk("first_req",  {31'd0, imem.imem_req}, 32'd1);
    chk("first_addr", imem.imem_addr,         32'h0000_3000);
    step();
    chk("wait_req",   {31'd0, imem.imem_req}, 32'd0);
    chk("wait_valid", {31'd0, IF_valid},      32'd0);
    stall = 1'b1;
    step();

    // Five stalled cycles with a full buffer
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'd0, IF_valid},      32'd1);
      chk("stall_pc4",   IF_pc4,                 32'h0000_3004);
      chk("stall_instr", IF_instr,               32'h2408_0001);
      chk("stall_req",   {31'd0, imem.imem_req}, 32'd0);
      step();
    end
    chk("stall_addr", imem.imem_addr, 32'h0000_3004);
    stall = 1'b0; #1;
    chk("rel_req",  {31'd0, imem.imem_req}, 32'd1);
    chk("rel_addr", imem.imem_addr,         32'h0000_3004);
    step();
    chk("consumed_valid", {31'd0, IF_valid}, 32'd0);
`ifdef IF_PERF_CNT_EN
    chk("perf_stall", perf_stall_cnt, 32'd5);
    chk("perf_fetch", perf_fetch_cnt, 32'd1);
`endif
    step();
    chk("f2_valid", {31'd0, IF_valid}, 32'd1);
    chk("f2_pc4",   IF_pc4,            32'h0000_3008);
    chk("f2_instr", IF_instr,          32'hDEAD_3004);
    chk("f2_addr",  imem.imem_addr,    32'h0000_3008);

    // Redirect while waiting on a 3-cycle response for 0x3008
    lat = 3;
    step();
    chk("w3_req", {31'd0, imem.imem_req}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_4000;
    step();
    redirect_valid = 1'b0; lat = 1;
    chk("drain_req",   {31'd0, imem.imem_req}, 32'd0);
    chk("drain_valid", {31'd0, IF_valid},      32'd0);
    chk("drain_addr",  imem.imem_addr,         32'h0000_4000);
    step();
    chk("drain2_req", {31'd0, imem.imem_req}, 32'd0);
    step();
    chk("drop_valid", {31'd0, IF_valid},      32'd0);
    chk("drop_req",   {31'd0, imem.imem_req}, 32'd1);
    chk("drop_addr",  imem.imem_addr,         32'h0000_4000);
`ifdef IF_PERF_CNT_EN
    chk("perf_kill1", perf_kill_cnt, 32'd1);
`endif
    step();
    step();
    chk("r_valid", {31'd0, IF_valid}, 32'd1);
    chk("r_pc4",   IF_pc4,            32'h0000_4004);
    chk("r_instr", IF_instr,          32'hDEAD_4000);

    // Redirect to unaligned 0x5002 coincident with the response for 0x4004
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_5002;
    step();
    redirect_valid = 1'b0;
    chk("co_valid", {31'd0, IF_valid},      32'd0);
    chk("co_req",   {31'd0, imem.imem_req}, 32'd1);
    chk("co_addr",  imem.imem_addr,         32'h0000_5000);
    step();
    step();
    chk("co2_pc4",   IF_pc4,   32'h0000_5004);
    chk("co2_instr", IF_instr, 32'hDEAD_5000);

    // Redirect in REQ with accept, to the top word, then wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("ra_req",  {31'd0, imem.imem_req}, 32'd0);
    chk("ra_addr", imem.imem_addr,         32'hFFFF_FFFC);
    step();
    chk("ra2_req", {31'd0, imem.imem_req}, 32'd1);
    step();
    step();
    chk("wrap_valid", {31'd0, IF_valid}, 32'd1);
    chk("wrap_pc4",   IF_pc4,            32'h0000_0000);
    chk("wrap_instr", IF_instr,          32'h2152_FFFC);
    chk("wrap_addr",  imem.imem_addr,    32'h0000_0000);

    // Get into DRAIN, then reset mid-drain
    lat = 3;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    chk("d_req", {31'd0, imem.imem_req}, 32'd0);
    rst_n = 1'b0; #1;
    chk("mr_req",   {31'd0, imem.imem_req}, 32'd0);
    chk("mr_valid", {31'd0, IF_valid},      32'd0);
    chk("mr_addr",  imem.imem_addr,         32'h0000_3000);
    step();
    step();
    lat = 1;
`ifdef IF_PERF_CNT_EN
    chk("mr_perf", perf_fetch_cnt | perf_stall_cnt | perf_kill_cnt, 32'd0);
`endif
    rst_n = 1'b1; #1;
    chk("rs_addr", imem.imem_addr, 32'h0000_3000);
    step();
    step();
    chk("rs_pc4",   IF_pc4,   32'h0000_3004);
    chk("rs_instr", IF_instr, 32'h2408_0001);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
